// File: rtl/vector_fetcher.sv
// vector_fetcher: pops column IDs from per-channel column FIFOs, reads the
// matching dense-vector element from one shared vector RAM read port and
// presents one element per channel on a valid/ready output.
//
// Pipeline per fetch (grant in cycle N):
//   N   : arbiter grants channel g, col_read[g] pulses, stage 1 loads tag g
//   N+1 : FIFO dout valid, vec_addr driven from the stage-1 tag, stage 2 loads
//   N+2 : vec_data valid, output register of the stage-2 channel loads
//   N+3 : out_valid[g] visible
//
// Build option: define RR_ARB_EN for round-robin arbitration with a rotating
// pointer. Without it the lowest eligible channel index always wins.
module vector_fetcher #(
  parameter int CHANNEL_NUM     = 4,
  parameter int CHANNEL_NUM_LOG = 2,
  parameter int COL_ID_SIZE     = 16,
  parameter int VEC_ADDR_SIZE   = 13,
  parameter int VAL_SIZE        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COL_ID_SIZE*CHANNEL_NUM-1:0] col_in,
  input  logic [CHANNEL_NUM-1:0]          col_empty,
  output logic [CHANNEL_NUM-1:0]          col_read,
  output logic [VEC_ADDR_SIZE-1:0]        vec_addr,
  input  logic [VAL_SIZE-1:0]             vec_data,
  output logic [VAL_SIZE*CHANNEL_NUM-1:0] out_data,
  output logic [CHANNEL_NUM-1:0]          out_valid,
  input  logic [CHANNEL_NUM-1:0]          out_ready
);

  // Output handshake: out_valid[c] is a registered flag. A transfer happens in
  // any cycle where out_valid[c] & out_ready[c]; out_valid[c] drops on the
  // following edge. While out_valid[c] is high and out_ready[c] low, out_data
  // for that channel does not change. A channel is only re-granted once its
  // output register is empty, so there is no back-to-back per channel.

  // Per-channel state
  logic [CHANNEL_NUM-1:0]          busy_q, busy_d;
  logic [CHANNEL_NUM-1:0]          out_valid_q, out_valid_d;
  logic [VAL_SIZE*CHANNEL_NUM-1:0] out_data_q, out_data_d;

  // Pipeline stages
  logic                       s1_valid_q, s1_valid_d;
  logic [CHANNEL_NUM_LOG-1:0] s1_tag_q, s1_tag_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [CHANNEL_NUM_LOG-1:0] s2_tag_q, s2_tag_d;

  // Last driven RAM address, held while stage 1 is idle
  logic [VEC_ADDR_SIZE-1:0] addr_hold_q, addr_hold_d;
  logic [VEC_ADDR_SIZE-1:0] addr_sel;

  // Arbitration
  logic [CHANNEL_NUM-1:0]     elig;
  logic [CHANNEL_NUM-1:0]     grant;
  logic                       grant_any;
  logic [CHANNEL_NUM_LOG-1:0] grant_idx;

  // Column ID bits above the RAM address width are deliberately ignored
  logic col_hi_unused;

`ifdef RR_ARB_EN
  logic [CHANNEL_NUM_LOG-1:0] ptr_q, ptr_d;
  logic [CHANNEL_NUM-1:0]     upper;
  logic                       upper_any;
  logic [CHANNEL_NUM_LOG-1:0] upper_idx;
  logic                       wrap_any;
  logic [CHANNEL_NUM_LOG-1:0] wrap_idx;
`endif

  // Eligibility from registered state only, then pick one channel
  always_comb begin
    elig      = ~col_empty & ~busy_q & ~out_valid_q;
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef RR_ARB_EN
    // Search [ptr, CHANNEL_NUM-1] first, then wrap around to [0, ptr-1]
    upper     = '0;
    upper_any = 1'b0;
    upper_idx = '0;
    wrap_any  = 1'b0;
    wrap_idx  = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      upper[c] = elig[c] && (CHANNEL_NUM_LOG'(c) >= ptr_q);
    end
    for (int c = CHANNEL_NUM - 1; c >= 0; c--) begin
      if (upper[c]) begin
        upper_any = 1'b1;
        upper_idx = CHANNEL_NUM_LOG'(c);
      end
      if (elig[c]) begin
        wrap_any = 1'b1;
        wrap_idx = CHANNEL_NUM_LOG'(c);
      end
    end
    if (upper_any) begin
      grant_any = 1'b1;
      grant_idx = upper_idx;
    end else if (wrap_any) begin
      grant_any = 1'b1;
      grant_idx = wrap_idx;
    end
`else
    // Fixed priority: descending scan so the lowest index is written last
    for (int c = CHANNEL_NUM - 1; c >= 0; c--) begin
      if (elig[c]) begin
        grant_any = 1'b1;
        grant_idx = CHANNEL_NUM_LOG'(c);
      end
    end
`endif
    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

`ifdef RR_ARB_EN
  // Advance the round-robin pointer past the granted channel
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == CHANNEL_NUM_LOG'(CHANNEL_NUM - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // FIFO read strobe is the grant, suppressed while in reset
  assign col_read = rst ? '0 : grant;

  // RAM address from the FIFO dout of the stage-1 channel
  always_comb begin
    addr_sel = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (s1_tag_q == CHANNEL_NUM_LOG'(c)) begin
        addr_sel = col_in[c*COL_ID_SIZE +: VEC_ADDR_SIZE];
      end
    end
    vec_addr    = s1_valid_q ? addr_sel : addr_hold_q;
    addr_hold_d = vec_addr;
  end

  // Fold the unused column ID bits together so they are visibly consumed
  always_comb begin
    col_hi_unused = 1'b0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      col_hi_unused = col_hi_unused ^
        (^col_in[c*COL_ID_SIZE+VEC_ADDR_SIZE +: COL_ID_SIZE-VEC_ADDR_SIZE]);
    end
  end

  // Pipeline stage advance: stage 1 follows the grant, stage 2 follows stage 1
  always_comb begin
    s1_valid_d = grant_any;
    s1_tag_d   = grant_idx;
    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
  end

  // Per-channel busy/output update: grant sets busy, RAM return loads the
  // output register and clears busy, a completed handshake clears valid.
  // Busy and out_valid are exclusive, so load and clear never collide.
  always_comb begin
    busy_d      = busy_q | grant;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    if (s2_valid_q) begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        if (s2_tag_q == CHANNEL_NUM_LOG'(c)) begin
          out_data_d[c*VAL_SIZE +: VAL_SIZE] = vec_data;
          out_valid_d[c]                     = 1'b1;
          busy_d[c]                          = 1'b0;
        end
      end
    end
  end

  // State registers; an in-flight fetch is dropped on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      addr_hold_q <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_vector_fetcher.sv
// Bench for vector_fetcher: FIFO and RAM models around the DUT, a per-cycle
// reference model of grants / latency / handshake, and scenario tasks.
module tb_vector_fetcher;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int AW = 13;
  localparam int VW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CW*CH-1:0] col_in;
  logic [CH-1:0]    col_empty;
  logic [CH-1:0]    col_read;
  logic [AW-1:0]    vec_addr;
  logic [VW-1:0]    vec_data;
  logic [VW*CH-1:0] out_data;
  logic [CH-1:0]    out_valid;
  logic [CH-1:0]    out_ready;

  vector_fetcher dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .col_empty(col_empty),
    .col_read (col_read),
    .vec_addr (vec_addr),
    .vec_data (vec_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- FIFO and RAM models ----------------
  logic [CW-1:0] fifo_q [CH][$];
  logic [CW-1:0] fifo_dout [CH];
  logic [CH-1:0] fifo_empty_r;
  logic [CH-1:0] force_empty;
  logic [VW-1:0] ram [0:(1<<AW)-1];

  assign col_empty = fifo_empty_r | force_empty;

  for (genvar g = 0; g < CH; g++) begin : g_col
    assign col_in[g*CW +: CW] = fifo_dout[g];
  end

  // Non-FWFT FIFO: data appears on dout the cycle after rd_en
  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (!rst && col_read[c] && fifo_q[c].size() > 0) begin
        fifo_dout[c] <= fifo_q[c].pop_front();
      end
      fifo_empty_r[c] <= (fifo_q[c].size() == 0);
    end
  end

  // RAM with one cycle read latency
  always @(posedge clk) begin
    vec_data <= ram[vec_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  int            cyc = 0;
  logic [CH-1:0] m_inflight = '0;
  logic [CH-1:0] m_valid = '0;
  int            m_due [CH];
  int            m_ptr = 0;
  int            addr_cyc = -1;
  logic [AW-1:0] addr_exp;
  int            xfers = 0;
  logic [VW-1:0] exp_q [CH][$];

  always @(negedge clk) begin
    logic [CH-1:0] elig;
    logic [CH-1:0] exp_rd;
    logic [CW-1:0] id;
    int g;
    int j;
    cyc++;
    if (rst) begin
      checks++;
      if (col_read !== '0) begin
        errors++;
        $display("FAIL reset_col_read cyc=%0d got=%b exp=0000", cyc, col_read);
      end
      m_inflight = '0;
      m_valid    = '0;
      m_ptr      = 0;
      addr_cyc   = -1;
      for (int c = 0; c < CH; c++) exp_q[c].delete();
    end else begin
      if (addr_cyc == cyc) begin
        checks++;
        if (vec_addr !== addr_exp) begin
          errors++;
          $display("FAIL vec_addr cyc=%0d got=%h exp=%h", cyc, vec_addr, addr_exp);
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (m_inflight[c] && m_due[c] == cyc) begin
          m_inflight[c] = 1'b0;
          m_valid[c]    = 1'b1;
        end
      end
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_valid);
      end
      for (int c = 0; c < CH; c++) begin
        if (m_valid[c] && exp_q[c].size() > 0) begin
          checks++;
          if (out_data[c*VW +: VW] !== exp_q[c][0]) begin
            errors++;
            $display("FAIL out_data ch%0d cyc=%0d got=%h exp=%h", c, cyc,
                     out_data[c*VW +: VW], exp_q[c][0]);
          end
        end
      end
      elig = ~col_empty & ~m_inflight & ~m_valid;
      g = -1;
`ifdef RR_ARB_EN
      for (int i = 0; i < CH; i++) begin
        j = (m_ptr + i) % CH;
        if (g < 0 && elig[j]) g = j;
      end
`else
      j = 0;
      for (int i = 0; i < CH; i++) begin
        if (g < 0 && elig[i]) g = i;
      end
`endif
      exp_rd = (g >= 0) ? (CH'(1) << g) : '0;
      checks++;
      if (col_read !== exp_rd) begin
        errors++;
        $display("FAIL col_read cyc=%0d got=%b exp=%b", cyc, col_read, exp_rd);
      end
      if (g >= 0 && fifo_q[g].size() > 0) begin
        id            = fifo_q[g][0];
        m_inflight[g] = 1'b1;
        m_due[g]      = cyc + 3;
        exp_q[g].push_back(ram[id[AW-1:0]]);
        addr_exp      = id[AW-1:0];
        addr_cyc      = cyc + 1;
        m_ptr         = (g + 1) % CH;
      end
      for (int c = 0; c < CH; c++) begin
        if (m_valid[c] && out_ready[c]) begin
          m_valid[c] = 1'b0;
          if (exp_q[c].size() > 0) void'(exp_q[c].pop_front());
          xfers++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst         = 1'b1;
    force_empty = '1;
    out_ready   = '0;
    for (int c = 0; c < CH; c++) fifo_q[c].delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    int n;
    idle = 1'b0;
    n    = 0;
    while (!idle && n < budget) begin
      tick();
      n++;
      idle = (m_inflight == '0) && (m_valid == '0);
      for (int c = 0; c < CH; c++) begin
        if (!force_empty[c] && fifo_q[c].size() != 0) idle = 1'b0;
      end
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL drain_timeout after %0d cycles inflight=%b valid=%b", n, m_inflight, m_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst         = 1'b1;
    force_empty = '1;
    out_ready   = '0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (col_read !== '0) begin
      errors++;
      $display("FAIL rst_col_read got=%b exp=0000", col_read);
    end
    checks++;
    if (out_valid !== '0) begin
      errors++;
      $display("FAIL rst_out_valid got=%b exp=0000", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL rst_out_data got=%h exp=0", out_data);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== '0) begin
      errors++;
      $display("FAIL post_rst_out_valid got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_single();
    tick();
    out_ready   = '1;
    force_empty = 4'b1110;
    fifo_q[0].push_back(16'h0005);
    tick();
    @(negedge clk);
    checks++;
    if (col_read !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got=%b exp=0001", col_read);
    end
    tick();
    @(negedge clk);
    checks++;
    if (vec_addr !== 13'd5) begin
      errors++;
      $display("FAIL single_addr got=%h exp=0005", vec_addr);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[15:0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_out got valid=%b data=%h exp valid=1 data=beef", out_valid[0], out_data[15:0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_clear got=%b exp=0", out_valid[0]);
    end
  endtask

  task automatic test_backpressure();
    tick();
    out_ready   = 4'b1110;
    force_empty = 4'b1110;
    fifo_q[0].push_back(16'h0005);
    fifo_q[0].push_back(16'h0007);
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[15:0] !== 16'hBEEF || col_read[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold i=%0d got valid=%b data=%h rd=%b exp valid=1 data=beef rd=0",
                 i, out_valid[0], out_data[15:0], col_read[0]);
      end
      tick();
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (col_read[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got rd=%b valid=%b exp rd=0 valid=1", col_read[0], out_valid[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (col_read[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_regrant got rd=%b valid=%b exp rd=1 valid=0", col_read[0], out_valid[0]);
    end
    wait_idle(50);
  endtask

  task automatic test_four_channels();
    logic [CH-1:0] exp_rd;
    do_reset();
    out_ready = '1;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 4; k++) fifo_q[c].push_back(CW'($urandom));
    end
    tick();
    force_empty = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_rd = CH'(1) << (i % CH);
      checks++;
      if (col_read !== exp_rd) begin
        errors++;
        $display("FAIL four_ch_order i=%0d got=%b exp=%b", i, col_read, exp_rd);
      end
      tick();
    end
    wait_idle(50);
  endtask

  task automatic test_empty_gating();
    do_reset();
    out_ready = '1;
    fifo_q[2].push_back(16'h0042);
    fifo_q[0].push_back(16'h0043);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (col_read !== '0 || out_valid !== '0) begin
        errors++;
        $display("FAIL empty_gate i=%0d got rd=%b valid=%b exp 0000/0000", i, col_read, out_valid);
      end
      tick();
    end
    force_empty = 4'b1011;
    @(negedge clk);
    checks++;
    if (col_read !== 4'b0100) begin
      errors++;
      $display("FAIL empty_release got=%b exp=0100", col_read);
    end
    wait_idle(50);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    out_ready   = '1;
    force_empty = 4'b1101;
    fifo_q[1].push_back(16'h0123);
    tick();
    @(negedge clk);
    checks++;
    if (col_read !== 4'b0010) begin
      errors++;
      $display("FAIL mid_grant got=%b exp=0010", col_read);
    end
    tick();
    rst = 1'b1;
    fifo_q[1].delete();
    @(negedge clk);
    checks++;
    if (col_read !== '0) begin
      errors++;
      $display("FAIL mid_rst_rd got=%b exp=0000", col_read);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== '0) begin
        errors++;
        $display("FAIL mid_after_rst i=%0d got=%b exp=0000", i, out_valid);
      end
      tick();
    end
    fifo_q[1].push_back(16'h0456);
    tick();
    @(negedge clk);
    checks++;
    if (col_read !== 4'b0010) begin
      errors++;
      $display("FAIL mid_regrant got=%b exp=0010", col_read);
    end
    wait_idle(50);
  endtask

  task automatic test_addr_trunc();
    do_reset();
    out_ready   = '1;
    force_empty = 4'b0111;
    fifo_q[3].push_back(16'hE00A);
    tick();
    @(negedge clk);
    checks++;
    if (col_read !== 4'b1000) begin
      errors++;
      $display("FAIL trunc_grant got=%b exp=1000", col_read);
    end
    tick();
    @(negedge clk);
    checks++;
    if (vec_addr !== 13'h000A) begin
      errors++;
      $display("FAIL trunc_addr got=%h exp=000a", vec_addr);
    end
    wait_idle(50);
  endtask

  task automatic test_random();
    int pushed;
    int x0;
    int c;
    do_reset();
    x0          = xfers;
    pushed      = 0;
    force_empty = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        c = $urandom_range(0, 2 * CH - 1);
        if (c >= CH) c = 0;
        fifo_q[c].push_back(CW'($urandom));
        pushed++;
      end
      out_ready = CH'($urandom);
      tick();
    end
    out_ready = '1;
    wait_idle(1500);
    checks++;
    if (xfers - x0 != pushed) begin
      errors++;
      $display("FAIL random_count got=%0d exp=%0d", xfers - x0, pushed);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    rst         = 1'b1;
    out_ready   = '0;
    force_empty = '1;
    for (int i = 0; i < (1 << AW); i++) ram[i] = VW'($urandom);
    ram[5]  = 16'hBEEF;
    ram[10] = 16'h1234;
    test_reset();
    test_single();
    test_backpressure();
    test_four_channels();
    test_empty_gating();
    test_reset_midflight();
    test_addr_trunc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
